// File: rtl/hps_ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hps_ext_pkg
//  Description : UIO command codes, event type codes, decode tags and small
//                helpers shared by the HPS extension command decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package hps_ext_pkg;

    // UIO command words (first word of a transaction)
    localparam logic [15:0] UIO_MOUSE_X   = 16'h0003;
    localparam logic [15:0] UIO_MOUSE_Y   = 16'h0004;
    localparam logic [15:0] UIO_KEYBOARD  = 16'h0005;
    localparam logic [15:0] UIO_DMA_WRITE = 16'h0061;
    localparam logic [15:0] UIO_DMA_READ  = 16'h0062;
    localparam logic [15:0] UIO_DMA_SDIO  = 16'h0063;
    localparam logic [15:0] UIO_KM_CLR    = 16'h0064;

    // Keyboard/mouse event type codes carried with each FIFO entry
    localparam logic [1:0] KM_TYPE_MOUSE_X  = 2'd0;
    localparam logic [1:0] KM_TYPE_MOUSE_Y  = 2'd1;
    localparam logic [1:0] KM_TYPE_KEYBOARD = 2'd2;

    // Upper bits of the DMA address word that mark a valid IDE access
    localparam logic [6:0] IDE_CS_TAG = 7'b1111000;
    // Marker nibble placed on top of every status word
    localparam logic [3:0] STATUS_TAG = 4'hE;

    // FIFO entry width: {type[1:0], payload[7:0]}
    localparam int KM_WIDTH = 10;

    typedef struct packed {
        logic [1:0] km_type;
        logic [7:0] data;
    } km_evt_t;

    // Map a keyboard/mouse command onto its event type code
    function automatic logic [1:0] km_type_of(input logic [15:0] cmd);
        logic [1:0] t;
        t = KM_TYPE_KEYBOARD;
        if (cmd == UIO_MOUSE_X) t = KM_TYPE_MOUSE_X;
        if (cmd == UIO_MOUSE_Y) t = KM_TYPE_MOUSE_Y;
        return t;
    endfunction

    // Register address after a transfer: low nibble steps until it reaches F
    // and then sticks; bit 4 selects the register bank and never moves.
    function automatic logic [4:0] addr_next(input logic [4:0] a);
        logic [4:0] n;
        n = a;
        if (a[3:0] != 4'hF) n = {a[4], a[3:0] + 4'd1};
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hps_km_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hps_km_fifo
//  Description : Synchronous keyboard/mouse event FIFO with valid/ready head,
//                full flag and simultaneous push/pop (also while full).
//  Revision    : 1.0  initial release
// ============================================================================
module hps_km_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_pop;
    logic w_accept;

    assign o_valid  = (r_count != '0);
    assign o_full   = (r_count == c_depth);
    assign o_data   = r_mem[r_rd_ptr];
    assign w_pop    = o_valid & i_ready;
    // A pop in the same cycle frees the slot the push is about to overwrite
    assign w_accept = i_push & (~o_full | w_pop);

    // Storage write; no reset needed since occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hps_ext_mc.sv
`default_nettype none
// ============================================================================
//  Module      : hps_ext_mc
//  Description : Multi-channel UIO command decoder between the HPS word bus
//                and the Amiga core: buffered keyboard/mouse events, IDE
//                register/DMA accesses to IDE_CH controllers, status readback.
//  Revision    : 1.0  initial release
// ============================================================================
module hps_ext_mc #(
    parameter int IDE_CH   = 2,
    parameter int KM_DEPTH = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 io_strobe,
    input  logic                 io_fpga,
    input  logic                 io_uio,
    input  logic [15:0]          io_din,
    output logic [15:0]          io_dout,
    input  logic [15:0]          fpga_dout,
    output logic                 km_valid,
    input  logic                 km_ready,
    output logic [1:0]           km_type,
    output logic [7:0]           km_data,
    output logic                 km_overflow,
    input  logic [16*IDE_CH-1:0] ide_din,
    output logic [15:0]          ide_dout,
    output logic [4:0]           ide_addr,
    output logic [IDE_CH-1:0]    ide_sel,
    output logic                 ide_rd,
    output logic                 ide_wr,
    input  logic [6*IDE_CH-1:0]  ide_req
);

    import hps_ext_pkg::*;

    localparam logic [4:0] c_wcnt_max = 5'd31;
    localparam logic [4:0] c_wcnt_ch  = 5'(IDE_CH);
    localparam logic [3:0] c_ch_lim   = 4'(IDE_CH);

    logic [4:0]  r_wcnt;
    logic [15:0] r_cmd;
    logic [3:0]  r_ch;
    logic        r_cs;
    logic [15:0] r_io_dout;

    logic              w_cmd_dma;
    logic              w_cmd_km;
    logic              w_cs_next;
    logic [IDE_CH-1:0] w_sel_dec;
    logic [15:0]       w_din_ch;
    logic [5:0]        w_req_k;
    logic              w_km_push;
    logic              w_km_full;
    logic              w_km_drop;
    km_evt_t           w_km_in;
    km_evt_t           w_km_head;

    assign io_dout   = io_fpga ? fpga_dout : r_io_dout;

    assign w_cmd_dma = (r_cmd == UIO_DMA_WRITE) || (r_cmd == UIO_DMA_READ);
    assign w_cmd_km  = (r_cmd == UIO_MOUSE_X) || (r_cmd == UIO_MOUSE_Y) ||
                       (r_cmd == UIO_KEYBOARD);
    // Channel number out of range deselects everything for this transaction
    assign w_cs_next = (io_din[15:9] == IDE_CS_TAG) && (io_din[7:4] < c_ch_lim);

    // One-hot decode of the channel field of the address word
    for (genvar g = 0; g < IDE_CH; g++) begin : g_sel
        assign w_sel_dec[g] = (io_din[7:4] == 4'(g));
    end

    // Channel muxes: read data of the selected channel, request flags for status word k
    always_comb begin
        w_din_ch = '0;
        w_req_k  = '0;
        for (int n = 0; n < IDE_CH; n++) begin
            if (r_ch == 4'(n))   w_din_ch = ide_din[16*n +: 16];
            if (r_wcnt == 5'(n)) w_req_k  = ide_req[6*n +: 6];
        end
    end

    // Command decode, word counter, IDE steering and address auto-increment
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wcnt    <= '0;
            r_cmd     <= '0;
            r_ch      <= '0;
            r_cs      <= 1'b0;
            r_io_dout <= '0;
            ide_dout  <= '0;
            ide_addr  <= '0;
            ide_sel   <= '0;
            ide_rd    <= 1'b0;
            ide_wr    <= 1'b0;
        end else begin
            ide_rd <= 1'b0;
            ide_wr <= 1'b0;
            // Step the address after each transfer; a pulse already issued
            // still completes this even if the transaction is aborted.
            if (ide_rd || ide_wr) ide_addr <= addr_next(ide_addr);

            if (!io_uio) begin
                r_wcnt    <= '0;
                r_cs      <= 1'b0;
                ide_sel   <= '0;
                r_io_dout <= '0;
            end else if (io_strobe) begin
                r_io_dout <= '0;
                ide_dout  <= io_din;
                if (r_wcnt != c_wcnt_max) r_wcnt <= r_wcnt + 5'd1;

                if (r_wcnt == 5'd0) begin
                    r_cmd   <= io_din;
                    r_cs    <= 1'b0;
                    ide_sel <= '0;
                    if (io_din == UIO_DMA_SDIO)
                        r_io_dout <= {STATUS_TAG, 6'b0, ide_req[5:0]};
                end else begin
                    if ((r_wcnt == 5'd1) && w_cmd_dma) begin
                        ide_addr <= {io_din[8], io_din[3:0]};
                        r_ch     <= io_din[7:4];
                        r_cs     <= w_cs_next;
                        ide_sel  <= w_cs_next ? w_sel_dec : '0;
                    end
                    if ((r_cmd == UIO_DMA_SDIO) && (r_wcnt < c_wcnt_ch))
                        r_io_dout <= {STATUS_TAG, 2'b00, r_wcnt[3:0], w_req_k};
                    if ((r_wcnt >= 5'd3) && r_cs) begin
                        if (r_cmd == UIO_DMA_WRITE) ide_wr <= 1'b1;
                        if (r_cmd == UIO_DMA_READ) begin
                            // Word present before the pulse is returned (prefetch)
                            r_io_dout <= w_din_ch;
                            ide_rd    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign w_km_push = io_uio && io_strobe && (r_wcnt == 5'd1) && w_cmd_km;
    assign w_km_in   = '{km_type: km_type_of(r_cmd), data: io_din[7:0]};
    assign w_km_drop = w_km_push && w_km_full && !(km_valid && km_ready);

    // Sticky overflow flag: set on a dropped event, cleared by KM_CLR
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            km_overflow <= 1'b0;
        end else if (io_uio && io_strobe && (r_wcnt == 5'd0) && (io_din == UIO_KM_CLR)) begin
            km_overflow <= 1'b0;
        end else if (w_km_drop) begin
            km_overflow <= 1'b1;
        end
    end

    hps_km_fifo #(
        .WIDTH (KM_WIDTH),
        .DEPTH (KM_DEPTH)
    ) u_km_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_push  (w_km_push),
        .i_data  (w_km_in),
        .o_valid (km_valid),
        .i_ready (km_ready),
        .o_data  (w_km_head),
        .o_full  (w_km_full)
    );

    assign km_type = w_km_head.km_type;
    assign km_data = w_km_head.data;

endmodule
`default_nettype wire
